// File: rtl/cache_cmd_dispatcher_if.sv
// Trace-in and L1 lookup handshake bundle for the command dispatcher.
// master = dispatcher side, slave = trace reader / cache lookup side.
interface cache_cmd_dispatcher_if #(
    parameter int ADDR_W    = 32,
    parameter int TAG_WIDTH = 12,
    parameter int SET_W     = 14
);
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           in_cmd;
    logic [ADDR_W-1:0]    in_addr;

    logic                 i_req_valid;
    logic                 i_req_ready;
    logic [TAG_WIDTH-1:0] i_req_tag;
    logic [SET_W-1:0]     i_req_set;

    logic                 d_req_valid;
    logic                 d_req_ready;
    logic [1:0]           d_req_op;
    logic [TAG_WIDTH-1:0] d_req_tag;
    logic [SET_W-1:0]     d_req_set;

    modport master (
        input  in_valid, in_cmd, in_addr, i_req_ready, d_req_ready,
        output in_ready, i_req_valid, i_req_tag, i_req_set,
               d_req_valid, d_req_op, d_req_tag, d_req_set
    );

    modport slave (
        output in_valid, in_cmd, in_addr, i_req_ready, d_req_ready,
        input  in_ready, i_req_valid, i_req_tag, i_req_set,
               d_req_valid, d_req_op, d_req_tag, d_req_set
    );
endinterface

// File: rtl/cache_cmd_dispatcher.sv
// Buffers trace commands in an in-order FIFO and dispatches them as I/D lookups,
// clear sweeps or print strobes; keeps saturating statistics counters.
module cache_cmd_dispatcher #(
    parameter int ADDR_W     = 32,
    parameter int TAG_WIDTH  = 12,
    parameter int SET_W      = 14,
    parameter int OFF_W      = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_cmd_dispatcher_if.master bus,
    output logic                 clr_valid,
    output logic [SET_W-1:0]     clr_set,
    output logic                 print_pulse,
    output logic                 busy,
    output logic [CNT_W-1:0]     rd_cnt,
    output logic [CNT_W-1:0]     wr_cnt,
    output logic [CNT_W-1:0]     if_cnt,
    output logic [CNT_W-1:0]     bad_cnt
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LINE_W = ADDR_W - OFF_W;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_ENTRY = 2'd1;
    localparam logic [1:0] ST_SWEEP = 2'd2;

    logic [3:0]        fifo_cmd  [FIFO_DEPTH];
    logic [LINE_W-1:0] fifo_line [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic              full, empty, push, pop;
    logic [3:0]        head_cmd;
    logic [LINE_W-1:0] head_line;

    logic [1:0]        state;
    logic [SET_W-1:0]  sweep_set;

    logic              i_v, d_v, go_clear, is_bad;
    logic [1:0]        d_op;
    logic              unused_off;

    // Byte offset never leaves the dispatcher; only tag+set are stored.
    assign unused_off = ^bus.in_addr[OFF_W-1:0];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign push  = bus.in_valid && !full;

    assign head_cmd  = fifo_cmd[rd_ptr[PTR_W-1:0]];
    assign head_line = fifo_line[rd_ptr[PTR_W-1:0]];

    always_comb begin
        i_v         = 1'b0;
        d_v         = 1'b0;
        d_op        = 2'd0;
        print_pulse = 1'b0;
        go_clear    = 1'b0;
        is_bad      = 1'b0;
        pop         = 1'b0;
        if (state == ST_RUN && !empty) begin
            case (head_cmd)
                4'd0: begin d_v = 1'b1; d_op = 2'd0; pop = bus.d_req_ready; end
                4'd1: begin d_v = 1'b1; d_op = 2'd1; pop = bus.d_req_ready; end
                4'd3: begin d_v = 1'b1; d_op = 2'd2; pop = bus.d_req_ready; end
                4'd4: begin d_v = 1'b1; d_op = 2'd3; pop = bus.d_req_ready; end
                4'd2: begin i_v = 1'b1; pop = bus.i_req_ready; end
                4'd8: begin go_clear = 1'b1; pop = 1'b1; end
                4'd9: begin print_pulse = 1'b1; pop = 1'b1; end
                default: begin is_bad = 1'b1; pop = 1'b1; end
            endcase
        end
    end

    assign bus.in_ready    = !full;
    assign bus.i_req_valid = i_v;
    assign bus.i_req_tag   = head_line[LINE_W-1 -: TAG_WIDTH];
    assign bus.i_req_set   = head_line[SET_W-1:0];
    assign bus.d_req_valid = d_v;
    assign bus.d_req_op    = d_op;
    assign bus.d_req_tag   = head_line[LINE_W-1 -: TAG_WIDTH];
    assign bus.d_req_set   = head_line[SET_W-1:0];

    assign clr_valid = (state == ST_SWEEP);
    assign clr_set   = sweep_set;
    assign busy      = !empty || (state != ST_RUN);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_cmd[wr_ptr[PTR_W-1:0]]  <= bus.in_cmd;
            fifo_line[wr_ptr[PTR_W-1:0]] <= bus.in_addr[ADDR_W-1:OFF_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            state     <= ST_RUN;
            sweep_set <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case (state)
                ST_RUN:   if (go_clear) state <= ST_ENTRY;
                ST_ENTRY: begin
                    state     <= ST_SWEEP;
                    sweep_set <= '0;
                end
                ST_SWEEP: begin
                    // Wraps back to 0 on the last set, leaving clr_set idle at 0.
                    sweep_set <= sweep_set + 1'b1;
                    if (sweep_set == {SET_W{1'b1}}) state <= ST_RUN;
                end
                default:  state <= ST_RUN;
            endcase
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || state == ST_ENTRY) begin
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            if_cnt  <= '0;
            bad_cnt <= '0;
        end else begin
            if (d_v && bus.d_req_ready && d_op == 2'd0) rd_cnt <= sat_inc(rd_cnt);
            if (d_v && bus.d_req_ready && d_op == 2'd1) wr_cnt <= sat_inc(wr_cnt);
            if (i_v && bus.i_req_ready)                 if_cnt <= sat_inc(if_cnt);
            if (is_bad)                                 bad_cnt <= sat_inc(bad_cnt);
        end
    end
endmodule
